usr_tx_ctrl: RTL and testbench

- Sequencing controller for the 8-bit universal shift register (USR).
- Accepts a parallel word over a valid/ready handshake and drives the USR select, parallel-load and serial-fill lines.
- Loads the word, then shifts it out one bit per accepted cycle, LSB-first or MSB-first, presenting each bit on a serial stream with its own valid/ready handshake.
- Sits between a byte-producing master and a serial link; the USR itself is instantiated alongside it, not inside it.

---
 rtl/usr_ctrl_pkg.sv | 25 ++
 rtl/USR_8bit.sv | 29 ++
 rtl/usr_tx_ctrl.sv | 140 ++++++++++++++
 tb/tb_usr_tx_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_ctrl_pkg.sv
// Shared encodings for the universal-shift-register transmit controller:
// USR select codes, shift-direction values, controller state type and a parity helper.
package usr_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_SHIFT  = 2'b10,
        ST_PARITY = 2'b11
    } state_t;

    // Even parity (XOR reduction) of a word zero-extended to 64 bits.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/USR_8bit.sv
// 8-bit universal shift register: hold, shift right, shift left, parallel load.
// Deliberately has no reset; its contents are always overwritten by a load before use.
module USR_8bit
    import usr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic [1:0] select,
    input  logic [7:0] pload,
    input  logic       L_in,
    input  logic       R_in,
    output logic [7:0] q
);

    logic [7:0] q_r;

    // Register update selected by the mode lines.
    always_ff @(posedge clk) begin
        case (select)
            SEL_HOLD: q_r <= q_r;
            SEL_SHR:  q_r <= {R_in, q_r[7:1]};
            SEL_SHL:  q_r <= {q_r[6:0], L_in};
            SEL_LOAD: q_r <= pload;
            default:  q_r <= q_r;
        endcase
    end

    assign q = q_r;

endmodule

// File: rtl/usr_tx_ctrl.sv
// Sequencing controller that loads a word into an external USR and streams it out serially.
// Optional trailing even-parity bit enabled by defining USR_TX_CTRL_PARITY_EN.
module usr_tx_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_fill,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_pload,
    output logic             usr_L_in,
    output logic             usr_R_in,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   word_r;
    logic               dir_r;
    logic               fill_r;
    logic               last_bit_s;
    logic               accept_s;
    logic               unused_q_bits_s;

    assign last_bit_s      = (cnt_r == CNT_W'(WIDTH - 1));
    assign accept_s        = in_valid & in_ready;
    assign usr_pload       = word_r;
    assign busy            = (state_r != ST_IDLE);
    // Only the two end bits of the USR are observed; the rest are shifted through.
    assign unused_q_bits_s = ^usr_q;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_LOAD;
                else          state_nxt_s = ST_IDLE;
            end
            ST_LOAD: state_nxt_s = ST_SHIFT;
            ST_SHIFT: begin
                if (ser_ready && last_bit_s) begin
`ifdef USR_TX_CTRL_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    if (accept_s) state_nxt_s = ST_LOAD;
                    else          state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
`ifdef USR_TX_CTRL_PARITY_EN
            ST_PARITY: begin
                if (!ser_ready)    state_nxt_s = ST_PARITY;
                else if (accept_s) state_nxt_s = ST_LOAD;
                else               state_nxt_s = ST_IDLE;
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; ser_* stays stable under backpressure because the USR holds.
    always_comb begin
        in_ready   = 1'b0;
        usr_select = SEL_HOLD;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_last   = 1'b0;
        usr_L_in   = 1'b0;
        usr_R_in   = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_LOAD: usr_select = SEL_LOAD;
            ST_SHIFT: begin
                ser_valid = 1'b1;
                if (dir_r == DIR_MSB_FIRST) ser_out = usr_q[WIDTH-1];
                else                        ser_out = usr_q[0];
`ifdef USR_TX_CTRL_PARITY_EN
                ser_last = 1'b0;
                in_ready = 1'b0;
`else
                ser_last = last_bit_s;
                in_ready = ser_ready & last_bit_s;
`endif
                if (!ser_ready)                  usr_select = SEL_HOLD;
                else if (dir_r == DIR_MSB_FIRST) usr_select = SEL_SHL;
                else                             usr_select = SEL_SHR;
                usr_R_in = fill_r & (dir_r == DIR_LSB_FIRST);
                usr_L_in = fill_r & (dir_r == DIR_MSB_FIRST);
            end
`ifdef USR_TX_CTRL_PARITY_EN
            ST_PARITY: begin
                ser_valid = 1'b1;
                ser_out   = even_parity(64'(word_r));
                ser_last  = 1'b1;
                in_ready  = ser_ready;
            end
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // State, bit counter and captured word/direction/fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            word_r  <= '0;
            dir_r   <= 1'b0;
            fill_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                word_r <= in_data;
                dir_r  <= in_dir;
                fill_r <= in_fill;
            end
            if (state_r == ST_LOAD)
                cnt_r <= '0;
            else if (state_r == ST_SHIFT && ser_ready)
                cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_usr_tx_ctrl.sv
// Scoreboard bench for usr_tx_ctrl driving a USR_8bit; honours USR_TX_CTRL_PARITY_EN.
module tb_usr_tx_ctrl;
    import usr_ctrl_pkg::*;

    localparam int W = 8;
`ifdef USR_TX_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_dir, in_fill;
    logic [W-1:0] in_data;
    logic         ser_out, ser_valid, ser_ready, ser_last;
    logic [1:0]   usr_select;
    logic [W-1:0] usr_pload, usr_q;
    logic         usr_L_in, usr_R_in, busy;

    logic [1:0]   exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    usr_tx_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last),
        .usr_select(usr_select), .usr_pload(usr_pload), .usr_L_in(usr_L_in),
        .usr_R_in(usr_R_in), .usr_q(usr_q), .busy(busy)
    );

    USR_8bit usr (
        .clk(clk), .select(usr_select), .pload(usr_pload),
        .L_in(usr_L_in), .R_in(usr_R_in), .q(usr_q)
    );

    // Expected {bit, last} stream for one word, in transmission order.
    task automatic push_word(input logic [W-1:0] w, input logic d);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = d ? w[W-1-i] : w[i];
            exp_q.push_back({b, (PAR == 0 && i == W-1) ? 1'b1 : 1'b0});
        end
        if (PAR != 0) exp_q.push_back({^w, 1'b1});
    endtask

    // Offer a word and return at the falling edge of the LOAD cycle.
    task automatic accept_word(input logic [W-1:0] w, input logic d, input logic f);
        bit got = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = w; in_dir = d; in_fill = f;
        for (int t = 0; t < 64 && !got; t++) begin
            #1; got = in_ready;
            if (!got) @(negedge clk);
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            push_word(w, d);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy actual=%b required=0", busy); end
        n_cmp++; if (in_ready !== 1'b1)      begin n_err++; $display("FAIL rst_in_ready actual=%b required=1", in_ready); end
        n_cmp++; if (ser_valid !== 1'b0)     begin n_err++; $display("FAIL rst_ser_valid actual=%b required=0", ser_valid); end
        n_cmp++; if (ser_last !== 1'b0)      begin n_err++; $display("FAIL rst_ser_last actual=%b required=0", ser_last); end
        n_cmp++; if (usr_select !== SEL_HOLD) begin n_err++; $display("FAIL rst_select actual=%b required=00", usr_select); end
        n_cmp++; if (usr_pload !== 8'h00)    begin n_err++; $display("FAIL rst_pload actual=%h required=00", usr_pload); end
        n_cmp++; if ({usr_L_in, usr_R_in} !== 2'b00) begin n_err++; $display("FAIL rst_serial_in actual=%b required=00", {usr_L_in, usr_R_in}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_word(input string tag, input logic [W-1:0] w, input logic d,
                                    input logic f, input logic [W-1:0] final_q);
        logic [1:0] e;
        int busy_cyc = 0;
        ser_ready = 1'b1;
        accept_word(w, d, f);
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) begin
            #1;
            if (busy) busy_cyc++;
            if (t == 0) begin
                n_cmp++;
                if (usr_select !== SEL_LOAD || usr_pload !== w) begin
                    n_err++; $display("FAIL %s_load select=%b pload=%h required=11/%h", tag, usr_select, usr_pload, w);
                end
            end
            if (ser_valid && ser_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({ser_out, ser_last} !== e) begin
                    n_err++; $display("FAIL %s_bit actual=%b required=%b", tag, {ser_out, ser_last}, e);
                end
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL %s_timeout left=%0d required=0", tag, exp_q.size()); end
        exp_q.delete();
        n_cmp++; if (busy_cyc != W + 1 + PAR) begin n_err++; $display("FAIL %s_busy_cycles actual=%0d required=%0d", tag, busy_cyc, W + 1 + PAR); end
        n_cmp++; if (usr_q !== final_q) begin n_err++; $display("FAIL %s_usr_q actual=%h required=%h", tag, usr_q, final_q); end
        n_cmp++; if (busy !== 1'b0 || ser_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle busy=%b valid=%b required=0/0", tag, busy, ser_valid); end
    endtask

    task automatic test_backpressure();
        logic [1:0] e;
        int  popped = 0, stalls = 0;
        bit  stalled = 1'b0;
        logic held = 1'b0;
        ser_ready = 1'b1;
        accept_word(8'hA5, 1'b0, 1'b0);
        for (int t = 0; t < 60 && exp_q.size() > 0; t++) begin
            #1;
            if (ser_valid && popped >= 2 && popped <= 4 && !stalled) begin
                ser_ready = 1'b0; stalled = 1'b1; held = ser_out; stalls++;
            end else begin
                ser_ready = 1'b1;
            end
            #1;
            if (ser_valid && !ser_ready) begin
                n_cmp++;
                if (usr_select !== SEL_HOLD) begin n_err++; $display("FAIL bp_stall_select actual=%b required=00", usr_select); end
            end
            if (ser_valid && ser_ready) begin
                if (stalled) begin
                    n_cmp++;
                    if (ser_out !== held) begin n_err++; $display("FAIL bp_hold actual=%b required=%b", ser_out, held); end
                    stalled = 1'b0;
                end
                if (popped < W) begin
                    n_cmp++;
                    if (usr_select !== SEL_SHR) begin n_err++; $display("FAIL bp_shift_select actual=%b required=01", usr_select); end
                end
                e = exp_q.pop_front();
                popped++;
                n_cmp++;
                if ({ser_out, ser_last} !== e) begin n_err++; $display("FAIL bp_bit actual=%b required=%b", {ser_out, ser_last}, e); end
            end
            @(negedge clk);
        end
        #1;
        ser_ready = 1'b1;
        n_cmp++; if (popped != W + PAR) begin n_err++; $display("FAIL bp_count actual=%0d required=%0d", popped, W + PAR); end
        n_cmp++; if (stalls != 3) begin n_err++; $display("FAIL bp_stalls actual=%0d required=3", stalls); end
        n_cmp++; if (usr_q !== 8'h00) begin n_err++; $display("FAIL bp_usr_q actual=%h required=00", usr_q); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int  nacc = 0, cyc = 0, popped = 0, last1 = -1, first2 = -1, loads = 0;
        bit  pend = 1'b0;
        ser_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h41; in_dir = 1'b0; in_fill = 1'b0;
        for (int t = 0; t < 80 && (nacc < 2 || exp_q.size() > 0); t++) begin
            #1;
            if (ser_valid && ser_ready) begin
                e = exp_q.pop_front();
                popped++;
                if (popped == W + PAR) last1 = cyc;
                if (popped == W + PAR + 1) first2 = cyc;
                n_cmp++;
                if ({ser_out, ser_last} !== e) begin n_err++; $display("FAIL b2b_bit actual=%b required=%b", {ser_out, ser_last}, e); end
            end
            if (last1 >= 0 && first2 < 0 && cyc > last1 && usr_select === SEL_LOAD) loads++;
            if (in_valid && in_ready) begin
                nacc++;
                pend = 1'b1;
                if (nacc == 2) begin
                    n_cmp++;
                    if (!(ser_valid && ser_last)) begin n_err++; $display("FAIL b2b_accept_cycle valid=%b last=%b required=1/1", ser_valid, ser_last); end
                end
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                push_word(in_data, in_dir);
                pend = 1'b0;
                if (nacc == 1) begin in_data = 8'h8E; in_dir = 1'b1; in_fill = 1'b1; end
                else in_valid = 1'b0;
            end
        end
        #1;
        in_valid = 1'b0;
        n_cmp++; if (nacc != 2 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_done accepts=%0d left=%0d required=2/0", nacc, exp_q.size()); end
        n_cmp++; if (first2 - last1 != 2) begin n_err++; $display("FAIL b2b_gap actual=%0d required=2", first2 - last1); end
        n_cmp++; if (loads != 1) begin n_err++; $display("FAIL b2b_loads actual=%0d required=1", loads); end
        n_cmp++; if (usr_q !== 8'hFF) begin n_err++; $display("FAIL b2b_usr_q actual=%h required=ff", usr_q); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        int popped = 0;
        ser_ready = 1'b1;
        accept_word(8'hA5, 1'b0, 1'b0);
        for (int t = 0; t < 40 && popped < 4; t++) begin
            #1;
            if (ser_valid && ser_ready) begin
                e = exp_q.pop_front();
                popped++;
                n_cmp++;
                if ({ser_out, ser_last} !== e) begin n_err++; $display("FAIL mid_bit actual=%b required=%b", {ser_out, ser_last}, e); end
            end
            @(negedge clk);
        end
        #2; rst_n = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0 || ser_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy_valid actual=%b%b required=00", busy, ser_valid); end
        n_cmp++; if (in_ready !== 1'b1 || usr_select !== SEL_HOLD) begin n_err++; $display("FAIL mid_rst_ready_sel actual=%b/%b required=1/00", in_ready, usr_select); end
        n_cmp++; if (usr_pload !== 8'h00 || usr_R_in !== 1'b0) begin n_err++; $display("FAIL mid_rst_pload actual=%h/%b required=00/0", usr_pload, usr_R_in); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        test_single_word("after_rst", 8'h3C, 1'b0, 1'b0, 8'h00);
    endtask

`ifdef USR_TX_CTRL_PARITY_EN
    task automatic test_parity();
        test_single_word("par_a5", 8'hA5, 1'b0, 1'b0, 8'h00);
        test_single_word("par_41", 8'h41, 1'b0, 1'b0, 8'h00);
        test_single_word("par_43", 8'h43, 1'b1, 1'b1, 8'hFF);
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_dir = 1'b0; in_fill = 1'b0; ser_ready = 1'b0;
        test_reset();
        test_single_word("lsb_a5", 8'hA5, 1'b0, 1'b0, 8'h00);
        test_single_word("msb_8e", 8'h8E, 1'b1, 1'b1, 8'hFF);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef USR_TX_CTRL_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
